// File: rtl/cp0_reg.sv
// OpenMIPS CP0: Count/Compare, Status, Cause, EPC, PRId, Config.
// Build option CP0_TIMER_INT_EN enables the Compare-match timer interrupt.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;
  localparam logic [4:0] A_CONFIG  = 5'd16;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_q, timer_d;

  logic       exc_vld;
  logic       eret;
  logic [4:0] exc_code;
  logic       wr;

  always_comb begin
    exc_vld  = 1'b1;
    eret     = 1'b0;
    exc_code = 5'd0;
    unique case (excepttype_i)
      32'h1:   exc_code = 5'h00;
      32'h8:   exc_code = 5'h08;
      32'ha:   exc_code = 5'h0a;
      32'hd:   exc_code = 5'h0d;
      32'hc:   exc_code = 5'h0c;
      32'he:   eret     = 1'b1;
      default: exc_vld  = 1'b0;
    endcase
  end

  // any nonzero exception type suppresses the mtc0 of that cycle
  assign wr = we_i && (excepttype_i == 32'd0);

  always_comb begin
    count_d         = count_q + 32'd1;
    compare_d       = compare_q;
    status_d        = status_q;
    cause_d         = cause_q;
    epc_d           = epc_q;
    timer_d         = timer_q;
    cause_d[15:10]  = int_i;
    if (wr) begin
      unique case (waddr_i)
        A_COUNT:   count_d   = data_i;
        A_COMPARE: compare_d = data_i;
        A_STATUS:  status_d  = data_i;
        A_EPC:     epc_d     = data_i;
        A_CAUSE: begin
          cause_d[9:8]   = data_i[9:8];
          cause_d[23:22] = data_i[23:22];
        end
        default: ;
      endcase
    end
`ifdef CP0_TIMER_INT_EN
    if (compare_q != 32'd0 && count_q == compare_q)
      timer_d = 1'b1;
    if (wr && waddr_i == A_COMPARE)
      timer_d = 1'b0;
`else
    timer_d = 1'b0;
`endif
    if (exc_vld && !eret) begin
      if (!status_q[1]) begin
        epc_d = is_in_delayslot_i ?
                current_inst_addr_i - 32'd4 :
                current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code;
    end else if (eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= STATUS_RESET;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timer_q;
`ifdef CP0_TIMER_INT_EN
  assign cause_o = cause_q | {16'd0, timer_q, 15'd0};
`else
  assign cause_o = cause_q;
`endif

  always_comb begin
    data_o = 32'd0;
    if (rst) begin
      unique case (raddr_i)
        A_COUNT:   data_o = count_o;
        A_COMPARE: data_o = compare_o;
        A_STATUS:  data_o = status_o;
        A_CAUSE:   data_o = cause_o;
        A_EPC:     data_o = epc_o;
        A_PRID:    data_o = prid_o;
        A_CONFIG:  data_o = config_o;
        default:   data_o = 32'd0;
      endcase
    end
  end

endmodule
